// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative radix-2 shift-add multiplier. One partial product is folded into a
// 2*WIDTH-bit accumulator per clock, so a multiplication takes exactly WIDTH
// CALC cycles regardless of operand values (fixed latency, no early exit).
//
// Signed operation is handled in sign-magnitude form. The operand magnitudes
// are multiplied as unsigned numbers, and the final accumulator value is
// negated when the operand signs differ. The magnitude of -2^(WIDTH-1) is
// 2^(WIDTH-1). That value still fits in WIDTH unsigned bits, so no extra
// width is needed.
//
// Parameters
//   WIDTH      operand width (>= 2); product is 2*WIDTH bits
//   SIGNED_EN  1: is_signed honoured, 0: always unsigned
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides everything)
//   in_valid   operand pair a/b/is_signed is valid
//   in_ready   block accepts operands (IDLE only)
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  operands and product are two's complement (sampled at accept)
//   out_valid  product is valid (DONE only)
//   out_ready  consumer takes the product
//   product    registered result, 2*WIDTH bits, held until next completion
//   busy       CALC or DONE (= !in_ready)
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude of a WIDTH-bit value. For the most negative
    // value the result is 2^(WIDTH-1), which is correct when read as unsigned.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (v[WIDTH-1]) begin
            res = ~v + WIDTH'(1'b1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Two's-complement negate of a full-width product.
    function automatic logic [PW-1:0] f_neg(input logic [PW-1:0] v);
        return ~v + PW'(1'b1);
    endfunction

    state_t             r_state;
    state_t             w_state_next;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [PW-1:0]      r_product;

    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CW-1:0]      r_cnt;
    logic               r_sgn;

    logic               w_is_signed_eff;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_result;

    // With SIGNED_EN=0 this folds to constant 0 and the sign logic disappears.
    assign w_is_signed_eff = is_signed & SIGNED_EN;
    assign w_accept        = (r_state == ST_IDLE) & in_valid;
    assign w_last          = (r_cnt == CNT_LAST);
    assign w_mag_a         = w_is_signed_eff ? f_abs(a) : a;
    assign w_mag_b         = w_is_signed_eff ? f_abs(b) : b;

    // Partial-product add: the multiplicand register is already pre-shifted
    // to the weight of the multiplier bit currently in position 0.
    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_result   = r_sgn ? f_neg(w_acc_next) : w_acc_next;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

    // Next-state logic for the IDLE -> CALC -> DONE -> IDLE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_DONE: begin
                // A handoff returns to IDLE. New operands are taken on the
                // following cycle, not in this one.
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake flags registered from the next state, so each one is a flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    // Datapath: operand capture, shift-add iteration and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
            r_sgn     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sgn   <= w_is_signed_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplr  <= w_mag_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= {r_mcand[PW-2:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CW'(1'b1);
                    // The last iteration writes the signed-corrected sum straight
                    // into the product register, so DONE has it on entry.
                    if (w_last) begin
                        r_product <= w_result;
                    end else begin
                        r_product <= r_product;
                    end
                end
                ST_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            is_signed = 1'b0;
    logic            out_ready = 1'b1;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;

    logic            in_ready, out_valid, busy;
    logic [2*W-1:0]  product;
    logic            u_in_ready, u_out_valid, u_busy;
    logic [2*W-1:0]  u_product;

    seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    // Unsigned-only build fed the same stimulus: it must ignore is_signed.
    seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(u_out_valid),
        .out_ready(out_ready), .product(u_product), .busy(u_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [31:0] mul_ref(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({48'd0, x}) * longint'({48'd0, y});
        return p[31:0];
    endfunction

    // Behavioural model: an operation occupies the block for W compute cycles,
    // then waits for out_ready; product holds its last value.
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_left  = 0;
    int          m_accepts = 0;
    logic [31:0] m_res = '0, m_res_u = '0, m_prod = '0, m_prod_u = '0;

    // Single compare process: check outputs, then advance the model for the next edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready",    in_ready,    !m_busy);
            chk("busy",        busy,        m_busy);
            chk("out_valid",   out_valid,   m_busy && m_left == 0);
            chk("product",     product,     m_prod);
            chk("u_in_ready",  u_in_ready,  !m_busy);
            chk("u_out_valid", u_out_valid, m_busy && m_left == 0);
            chk("u_product",   u_product,   m_prod_u);
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_left = 0; m_prod = '0; m_prod_u = '0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1; m_left = W; m_accepts++;
                    m_res   = mul_ref(a, b, is_signed);
                    m_res_u = mul_ref(a, b, 1'b0);
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_prod = m_res; m_prod_u = m_res_u; end
            end else if (out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 64 && !in_ready; k++) tick();
        chk({nm, "_idle"}, in_ready, 1'b1);
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input logic [31:0] lit, input logic [31:0] lit_u, input string nm);
        int lat;
        wait_idle(nm);
        out_ready = 1'b1;
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_valid) begin lat = k; break; end
        end
        chk({nm, "_latency"},   lat, 64'd16);
        chk({nm, "_product"},   product, lit);
        chk({nm, "_product_u"}, u_product, lit_u);
        tick();                       // handoff
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int acc_cyc[$];
        int start, cyc, seen;
        logic [31:0] exp_p;

        // Pin the reference model with hand-computed values.
        chk("model_umax",   mul_ref(16'hFFFF, 16'hFFFF, 1'b0), 32'hFFFE0001);
        chk("model_smin2",  mul_ref(16'h8000, 16'h8000, 1'b1), 32'h40000000);
        chk("model_sneg",   mul_ref(16'h8000, 16'h0001, 1'b1), 32'hFFFF8000);
        chk("model_u1234",  mul_ref(16'h1234, 16'h5678, 1'b0), 32'h06260060);

        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready",  in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy",      busy, 1'b0);
        chk("reset_product",   product, 32'h0);

        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'hFFFE0001, "umax");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 32'hFFFE0001, "s_m1m1");
        do_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 32'h40000000, "s_minmin");
        do_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 32'h00008000, "s_min1");
        do_op(16'h0000, 16'h8000, 1'b1, 32'h00000000, 32'h00000000, "s_zero");
        do_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 32'h3FFF8000, "s_maxmin");

        // Backpressure: hold out_ready low in DONE, with new operands offered.
        wait_idle("bp");
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h5678; is_signed = 1'b0; in_valid = 1'b1;
        exp_p = 32'h06260060;
        tick();
        a = 16'h0003; b = 16'h0005; is_signed = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !out_valid; k++) tick();
        chk("bp_reached_done", out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready",  in_ready, 1'b0);
            chk("bp_product",   product, exp_p);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_idle",  in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_product_kept",  product, exp_p);
        tick();                       // pending operands accepted now
        in_valid = 1'b0;
        chk("bp_next_accepted", busy, 1'b1);
        wait_idle("bp_next");
        chk("bp_next_product", product, 32'd15);

        // Back-to-back with operands changing every cycle.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
            if (in_ready) acc_cyc.push_back(k);
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_count", acc_cyc.size() >= 3, 1'b1);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 64'd18);
        wait_idle("b2b_end");

        // Reset in the middle of CALC aborts the operation.
        a = 16'h00FF; b = 16'h00FF; is_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_in_ready",  in_ready, 1'b1);
        chk("rst_mid_product",   product, 32'h0);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_mid_no_valid", seen, 64'd0);

        // Random traffic with random backpressure; the compare process checks it.
        start = m_accepts;
        cyc = 0;
        while ((m_accepts - start) < 2000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            is_signed = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            cyc++;
        end
        chk("rand_ops_done", (m_accepts - start) >= 2000, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle("final");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
